// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_stage
//  Brief    : Fully registered valid/ready stage with a one-entry skid buffer,
//             synchronous flush and an output-transfer counter.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] xfer_count
);

    // State encoding doubles as the occupancy value.
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic [CNT_W-1:0] r_xfer_count;

    logic             w_in_hs;
    logic             w_out_hs;
    logic [1:0]       w_next_state;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;

    assign w_in_hs  = in_valid & r_in_ready;
    assign w_out_hs = r_out_valid & out_ready;

    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            c_EMPTY: begin
                if (w_in_hs) begin
                    w_next_state   = c_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            c_ONE: begin
                if (w_in_hs && w_out_hs) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_hs) begin
                    w_next_state = c_FULL;
                    w_load_skid  = 1'b1;
                end else if (w_out_hs) begin
                    w_next_state = c_EMPTY;
                end
            end
            c_FULL: begin
                if (w_out_hs) begin
                    w_next_state     = c_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_next_state = c_EMPTY;
            end
        endcase
        // Flush discards everything held; data registers keep stale contents.
        if (flush) begin
            w_next_state     = c_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_EMPTY;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
            r_xfer_count <= '0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state != c_FULL);
            r_out_valid <= (w_next_state != c_EMPTY);
            if (w_load_main_in) begin
                r_main_data <= in_data;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
            end
            // A transfer completing in a flush cycle still counts.
            if (w_out_hs) begin
                r_xfer_count <= r_xfer_count + 1'b1;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_main_data;
    assign occupancy  = r_state;
    assign xfer_count = r_xfer_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_skid_stage
//  Brief    : Directed + random scoreboard bench for pipe_skid_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] xfer_count;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO contents and expected transfer count.
    logic [WIDTH-1:0] q[$];
    logic [CNT_W-1:0] m_cnt;

    pipe_skid_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, advance model, then run one clock.
    task automatic cyc();
        int  occ;
        bit  in_hs;
        bit  out_hs;
        occ = q.size();
        chk("out_valid", {31'd0, out_valid}, {31'd0, occ != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, occ != 2});
        chk("occupancy", {30'd0, occupancy}, occ);
        chk("xfer_count", {28'd0, xfer_count}, {28'd0, m_cnt});
        if (occ != 0) chk("out_data", {24'd0, out_data}, {24'd0, q[0]});
        in_hs  = in_valid && (occ != 2);
        out_hs = (occ != 0) && out_ready;
        if (rst) begin
            q.delete();
            m_cnt = '0;
        end else begin
            if (out_hs) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 1'b1;
            end
            if (flush) q.delete();
            else if (in_hs) q.push_back(in_data);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cyc();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
        m_cnt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
        chk("rst_xfer_count", {28'd0, xfer_count}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        cyc();

        // Streaming 01..10 with out_ready high.
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) push(i[7:0]);
        in_valid = 1'b0;
        cyc(); cyc();
        chk("stream_count_wrapped", {28'd0, xfer_count}, 32'd0);

        // Backpressure: 20 on output, ready low two cycles.
        push(8'h20);
        out_ready = 1'b0;
        push(8'h21);
        chk("bp_full_occ", {30'd0, occupancy}, 32'd2);
        push(8'h22);
        out_ready = 1'b1;
        push(8'h22);
        push(8'h22);
        in_valid = 1'b0;
        cyc(); cyc();

        // Flush while FULL with a pending input.
        out_ready = 1'b0;
        push(8'h30);
        push(8'h31);
        flush = 1'b1;
        push(8'h32);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        cyc(); cyc();

        // Flush with a simultaneous output handshake.
        push(8'h40);
        in_valid = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_hs_occ", {30'd0, occupancy}, 32'd0);
        cyc();

        // Counter wrap: 17 more transfers.
        for (int i = 0; i < 17; i++) push(8'h50 + i[7:0]);
        in_valid = 1'b0;
        cyc(); cyc();

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom_range(0, 255);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            cyc();
        end
        flush = 1'b0;

        // Reset mid-stream with two words held.
        out_ready = 1'b0;
        in_valid = 1'b0;
        cyc(); cyc();
        push(8'h60);
        push(8'h61);
        chk("pre_rst_occ", {30'd0, occupancy}, 32'd2);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h62; out_ready = 1'b1;
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        chk("mid_rst_out_data", {24'd0, out_data}, 32'd0);
        chk("mid_rst_count", {28'd0, xfer_count}, 32'd0);
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Registered valid/ready pipeline stage with a one-entry skid buffer, placed directly upstream of the team's plain resettable data registers. It breaks both the forward (valid/data) and backward (ready) combinational paths, so no upstream or downstream logic sees a combinational path through the stage. It holds at most two words, supports a synchronous flush, and counts completed output transfers for debug.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- CNT_W, 16, width of the transfer counter (≥1)

- clk  in  1  clock; all state updates on posedge clk
- rst  in  1  reset rst, synchronous, active-high; clock clk
- flush  in  1  synchronous discard of all held words; priority below rst
- in_valid  in  1  upstream word present
- in_ready  out  1  stage can accept; driven directly from a flop
- in_data  in  WIDTH  upstream word
- out_valid  out  1  main register holds a word; driven directly from a flop
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  main register contents
- occupancy  out  2  words held: 0, 1 or 2
- xfer_count  out  CNT_W  completed output handshakes, modulo 2^CNT_W

## Operation
- Input handshake: in_valid & in_ready at a posedge. Output handshake: out_valid & out_ready at a posedge.
- Storage: main register (main_data, feeds out_data) and skid register (skid_data).
- States: EMPTY (occupancy 0), ONE (1), FULL (2). in_ready = (state != FULL). out_valid = (state != EMPTY). Both are registered and updated with the state.
- EMPTY:
  - input handshake → ONE, main_data <= in_data.
  - otherwise stay in EMPTY.
- ONE:
  - input and output handshakes together → ONE, main_data <= in_data.
  - input handshake only → FULL, skid_data <= in_data, main_data unchanged.
  - output handshake only → EMPTY.
  - neither → hold.
- FULL (in_valid ignored, in_ready = 0):
  - output handshake → ONE, main_data <= skid_data.
  - otherwise hold.
- Ordering: first in, first out always. No word is duplicated or lost except by flush or rst.
- Data registers load only on the cases listed above. They hold otherwise, including the stale value in EMPTY.
- flush (rst = 0):
  - next state EMPTY, in_ready 1, out_valid 0.
  - data registers hold.
  - an input handshake in the flush cycle is discarded.
  - an output handshake in the flush cycle is complete and is counted.
- xfer_count increments by 1 on each output handshake and wraps from 2^CNT_W−1 to 0.
- out_valid never drops without an output handshake, flush or rst.
- out_data is stable while out_valid & !out_ready.

## Timing
- All outputs are registered; no combinational input-to-output path exists.
- Reset (rst high at a posedge), effective the next cycle: state EMPTY, out_valid 0, in_ready 1, out_data 0, skid_data 0, occupancy 0, xfer_count 0.
- rst overrides flush and both handshakes.
- Reset mid-operation drops held words, with no handshake counted in that cycle.
- Latency: a word accepted at edge N appears on out_data with out_valid = 1 after edge N (1 cycle) when the stage was EMPTY, or when it was ONE with a simultaneous output handshake.
- Throughput: 1 word per cycle sustained while out_ready stays high.
- Backpressure: out_ready low for one cycle while streaming causes FULL after that edge, so in_ready reads 0 for the next cycle. in_ready returns to 1 one cycle after the draining output handshake.
- Maximum words accepted after out_ready falls: 1 (held in skid).

## Test plan
- Reset: rst = 1 for 2 cycles with in_valid = 1, in_data = 8'hAA → after release, out_valid 0, in_ready 1, occupancy 0, xfer_count 0, no output handshake.
- Streaming: out_ready = 1, push 8'h01..8'h10 on consecutive cycles → outputs 8'h01..8'h10 in order, each 1 cycle after acceptance; xfer_count = 16; in_ready never 0.
- Backpressure: stream 8'h20, 8'h21, 8'h22 with out_ready low for the 2 cycles after 8'h20 appears:
  - 8'h20 holds on out_data.
  - 8'h21 lands in skid, occupancy 2, in_ready 0.
  - 8'h22 waits upstream.
  - once out_ready rises, order is 8'h20, 8'h21, 8'h22 with no loss.
- Flush while FULL (8'h30 main, 8'h31 skid), out_ready = 0, in_valid = 1 with 8'h32 → next cycle EMPTY, out_valid 0, in_ready 1; 8'h32 never appears; xfer_count unchanged.
- Flush with simultaneous output handshake → xfer_count +1; stage EMPTY next cycle.
- Counter wrap: CNT_W = 4, 17 output transfers → xfer_count = 1; reset mid-stream with occupancy 2 → all outputs at reset values next cycle.
